// File: rtl/noc_pkg.sv
// Shared flit format for the PE network interface: field widths, offsets,
// packet types and pack/unpack helpers.
package noc_pkg;

   localparam int FLIT_W   = 35;
   localparam int ADDR_W   = 4;
   localparam int TYPE_W   = 2;
   localparam int DATA_W   = 25;

   localparam int DEST_LSB = 31;
   localparam int SRC_LSB  = 27;
   localparam int TYPE_LSB = 25;

   typedef enum logic [TYPE_W-1:0] {
      PKT_SPIKE  = 2'b00,
      PKT_WEIGHT = 2'b01,
      PKT_PSUM   = 2'b10,
      PKT_CTRL   = 2'b11
   } pkt_type_e;

   typedef struct packed {
      logic [ADDR_W-1:0] dest;
      logic [ADDR_W-1:0] src;
      pkt_type_e         typ;
      logic [DATA_W-1:0] data;
   } flit_t;

   function automatic flit_t pack_flit(input logic [ADDR_W-1:0] dest,
                                       input logic [ADDR_W-1:0] src,
                                       input pkt_type_e         typ,
                                       input logic [DATA_W-1:0] data);
      flit_t f;
      f.dest = dest;
      f.src  = src;
      f.typ  = typ;
      f.data = data;
      return f;
   endfunction

   function automatic flit_t unpack_flit(input logic [FLIT_W-1:0] raw);
      flit_t f;
      f.dest = raw[DEST_LSB +: ADDR_W];
      f.src  = raw[SRC_LSB +: ADDR_W];
      f.typ  = pkt_type_e'(raw[TYPE_LSB +: TYPE_W]);
      f.data = raw[DATA_W-1:0];
      return f;
   endfunction

endpackage

// File: rtl/noc_pe_interface_if.sv
// Handshake bundle between the PE, this network interface and the router PE port.
// slave = the network interface itself, master = the PE/router side driving it.
interface noc_pe_interface_if;
   import noc_pkg::*;

   logic              pe_tx_valid;
   logic              pe_tx_ready;
   logic [ADDR_W-1:0] pe_tx_dest;
   logic [TYPE_W-1:0] pe_tx_type;
   logic [DATA_W-1:0] pe_tx_data;

   logic              net_out_valid;
   logic              net_out_ready;
   logic [FLIT_W-1:0] net_out_flit;

   logic              net_in_valid;
   logic              net_in_ready;
   logic [FLIT_W-1:0] net_in_flit;

   logic              pe_rx_valid;
   logic              pe_rx_ready;
   logic [ADDR_W-1:0] pe_rx_src;
   logic [TYPE_W-1:0] pe_rx_type;
   logic [DATA_W-1:0] pe_rx_data;

   modport slave (
      input  pe_tx_valid, pe_tx_dest, pe_tx_type, pe_tx_data,
      output pe_tx_ready,
      output net_out_valid, net_out_flit,
      input  net_out_ready,
      input  net_in_valid, net_in_flit,
      output net_in_ready,
      output pe_rx_valid, pe_rx_src, pe_rx_type, pe_rx_data,
      input  pe_rx_ready
   );

   modport master (
      output pe_tx_valid, pe_tx_dest, pe_tx_type, pe_tx_data,
      input  pe_tx_ready,
      input  net_out_valid, net_out_flit,
      output net_out_ready,
      output net_in_valid, net_in_flit,
      input  net_in_ready,
      input  pe_rx_valid, pe_rx_src, pe_rx_type, pe_rx_data,
      output pe_rx_ready
   );

endinterface

// File: rtl/noc_sync_fifo.sv
// Single-clock FIFO with occupancy count; head entry is always visible on rdata.
// Push while full and pop while empty are ignored.
module noc_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rdata,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             do_push, do_pop;

   // Explicit wrap keeps non-power-of-two depths correct.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
   endfunction

   assign full  = (cnt_q == CNT_W'(DEPTH));
   assign empty = (cnt_q == '0);
   assign count = cnt_q;
   assign rdata = mem_q[rd_ptr_q];

   always_comb begin
      do_push  = push && !full;
      do_pop   = pop && !empty;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/noc_pe_interface.sv
// PE-side network interface: formats PE requests into flits toward the router,
// and filters/delivers router flits addressed to this node back to the PE.
//
//   state     | meaning
//   OUT_EMPTY | output register empty, net_out_valid low
//   OUT_HOLD  | output register holds a flit, net_out_valid high
module noc_pe_interface #(
   parameter int NODE_ID  = 0,
   parameter int FLIT_W   = 35,
   parameter int ADDR_W   = 4,
   parameter int TYPE_W   = 2,
   parameter int DATA_W   = 25,
   parameter int TX_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   noc_pe_interface_if.slave           bus,
   output logic [7:0]                  misroute_cnt,
   output logic [$clog2(TX_DEPTH):0]   tx_level
);

   import noc_pkg::*;

   localparam int LVL_W     = $clog2(TX_DEPTH) + 1;
   localparam int TXF_DEPTH = TX_DEPTH - 1;
   localparam int TXF_CNT_W = $clog2(TXF_DEPTH + 1);
   localparam int RX_W      = FLIT_W - ADDR_W;

   if (DATA_W != FLIT_W - 2*ADDR_W - TYPE_W) begin : g_bad_widths
      $error("noc_pe_interface: DATA_W must equal FLIT_W-2*ADDR_W-TYPE_W");
   end
   if (FLIT_W != noc_pkg::FLIT_W || ADDR_W != noc_pkg::ADDR_W ||
       TYPE_W != noc_pkg::TYPE_W) begin : g_bad_pkg
      $error("noc_pe_interface: widths must match noc_pkg");
   end
   if (TX_DEPTH < 2 || TX_DEPTH > 16 || (TX_DEPTH & (TX_DEPTH-1)) != 0) begin : g_bad_depth
      $error("noc_pe_interface: TX_DEPTH must be a power of two in 2..16");
   end

   typedef enum logic {OUT_EMPTY, OUT_HOLD} out_state_e;

   out_state_e        state_q, state_d;
   logic [FLIT_W-1:0] out_flit_q, out_flit_d;
   logic              live_q;
   logic [7:0]        misroute_q, misroute_d;

   logic                 tx_push, txf_push, txf_pop, bypass;
   logic [FLIT_W-1:0]    new_flit, txf_rdata;
   logic [TXF_CNT_W-1:0] txf_count;
   logic                 txf_full, txf_empty;

   flit_t             rx_flit;
   logic              rx_accept, rx_local, rxf_push, rxf_pop;
   logic [RX_W-1:0]   rxf_wdata, rxf_rdata;
   logic [1:0]        rxf_count;
   logic              rxf_full, rxf_empty;

   // Readies stay low until the first clock after reset release.
   assign tx_level        = LVL_W'(txf_count) + LVL_W'(state_q == OUT_HOLD);
   assign bus.pe_tx_ready = live_q && (tx_level < LVL_W'(TX_DEPTH));
   assign tx_push         = bus.pe_tx_valid && bus.pe_tx_ready;
   assign new_flit        = pack_flit(bus.pe_tx_dest, ADDR_W'(NODE_ID),
                                      pkt_type_e'(bus.pe_tx_type), bus.pe_tx_data);
   assign txf_push        = tx_push && !bypass;

   noc_sync_fifo #(.WIDTH(FLIT_W), .DEPTH(TXF_DEPTH)) u_tx_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (txf_push),
      .wdata (new_flit),
      .pop   (txf_pop),
      .rdata (txf_rdata),
      .count (txf_count),
      .full  (txf_full),
      .empty (txf_empty)
   );

   // A push onto an empty queue bypasses the FIFO so it is visible next cycle.
   always_comb begin
      state_d    = state_q;
      out_flit_d = out_flit_q;
      txf_pop    = 1'b0;
      bypass     = 1'b0;
      case (state_q)
         OUT_EMPTY: begin
            if (!txf_empty) begin
               out_flit_d = txf_rdata;
               txf_pop    = 1'b1;
               state_d    = OUT_HOLD;
            end else if (tx_push) begin
               out_flit_d = new_flit;
               bypass     = 1'b1;
               state_d    = OUT_HOLD;
            end
         end
         OUT_HOLD: begin
            if (bus.net_out_ready) begin
               if (!txf_empty) begin
                  out_flit_d = txf_rdata;
                  txf_pop    = 1'b1;
               end else if (tx_push) begin
                  out_flit_d = new_flit;
                  bypass     = 1'b1;
               end else begin
                  state_d = OUT_EMPTY;
               end
            end
         end
         default: state_d = OUT_EMPTY;
      endcase
   end

   assign bus.net_out_valid = (state_q == OUT_HOLD);
   assign bus.net_out_flit  = out_flit_q;

   assign rx_flit          = unpack_flit(bus.net_in_flit);
   assign bus.net_in_ready = live_q && !rxf_full;
   assign rx_accept        = bus.net_in_valid && bus.net_in_ready;
   assign rx_local         = (rx_flit.dest == ADDR_W'(NODE_ID));
   assign rxf_push         = rx_accept && rx_local;
   assign rxf_wdata        = {rx_flit.src, rx_flit.typ, rx_flit.data};
   assign rxf_pop          = bus.pe_rx_valid && bus.pe_rx_ready;

   noc_sync_fifo #(.WIDTH(RX_W), .DEPTH(2)) u_rx_skid (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (rxf_push),
      .wdata (rxf_wdata),
      .pop   (rxf_pop),
      .rdata (rxf_rdata),
      .count (rxf_count),
      .full  (rxf_full),
      .empty (rxf_empty)
   );

   assign bus.pe_rx_valid = !rxf_empty;
   assign bus.pe_rx_src   = rxf_empty ? '0 : rxf_rdata[RX_W-1 -: ADDR_W];
   assign bus.pe_rx_type  = rxf_empty ? '0 : rxf_rdata[DATA_W +: TYPE_W];
   assign bus.pe_rx_data  = rxf_empty ? '0 : rxf_rdata[DATA_W-1:0];

   always_comb begin
      misroute_d = misroute_q;
      if (rx_accept && !rx_local && misroute_q != 8'hFF) begin
         misroute_d = misroute_q + 8'd1;
      end
   end

   assign misroute_cnt = misroute_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= OUT_EMPTY;
         out_flit_q <= '0;
         live_q     <= 1'b0;
         misroute_q <= '0;
      end else begin
         state_q    <= state_d;
         out_flit_q <= out_flit_d;
         live_q     <= 1'b1;
         misroute_q <= misroute_d;
      end
   end

endmodule

// File: tb/tb_noc_pe_interface.sv
// Scoreboard bench for noc_pe_interface at NODE_ID=5, TX_DEPTH=4.
module tb_noc_pe_interface;
   import noc_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] misroute_cnt;
   logic [2:0] tx_level;

   int n_chk = 0;
   int n_bad = 0;

   logic [34:0] tx_exp [$];
   logic [30:0] rx_exp [$];

   noc_pe_interface_if bus();

   noc_pe_interface #(.NODE_ID(5), .TX_DEPTH(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus),
      .misroute_cnt (misroute_cnt),
      .tx_level     (tx_level)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tx_send(input logic [3:0] d, input logic [1:0] t, input logic [24:0] x);
      bit ok;
      ok = 1'b0;
      bus.pe_tx_valid = 1'b1;
      bus.pe_tx_dest  = d;
      bus.pe_tx_type  = t;
      bus.pe_tx_data  = x;
      tx_exp.push_back({d, 4'd5, t, x});
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         ok = bus.pe_tx_ready;
         @(posedge clk);
      end
      #1;
      bus.pe_tx_valid = 1'b0;
      if (!ok) chk("tx_push_timeout", 64'(ok), 64'd1);
   endtask

   task automatic rx_send(input logic [34:0] f);
      bit ok;
      ok = 1'b0;
      bus.net_in_valid = 1'b1;
      bus.net_in_flit  = f;
      if (f[34:31] == 4'd5) rx_exp.push_back(f[30:0]);
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         ok = bus.net_in_ready;
         @(posedge clk);
      end
      #1;
      bus.net_in_valid = 1'b0;
      if (!ok) chk("rx_push_timeout", 64'(ok), 64'd1);
   endtask

   task automatic tx_drain();
      for (int i = 0; i < 100 && tx_exp.size() != 0; i++) @(posedge clk);
      #1;
      chk("tx_drain_left", 64'(tx_exp.size()), 64'd0);
   endtask

   task automatic rx_drain();
      for (int i = 0; i < 100 && rx_exp.size() != 0; i++) @(posedge clk);
      #1;
      chk("rx_drain_left", 64'(rx_exp.size()), 64'd0);
   endtask

   // Transfers are judged on the falling edge before the rising edge that takes them.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.net_out_valid && bus.net_out_ready) begin
            if (tx_exp.size() == 0) chk("tx_unexpected_valid", 64'(bus.net_out_valid), 64'd0);
            else chk("tx_flit", 64'(bus.net_out_flit), 64'(tx_exp.pop_front()));
         end
         if (bus.pe_rx_valid) begin
            if (rx_exp.size() == 0) chk("rx_unexpected_valid", 64'(bus.pe_rx_valid), 64'd0);
            else if (bus.pe_rx_ready)
               chk("rx_pkt", 64'({bus.pe_rx_src, bus.pe_rx_type, bus.pe_rx_data}),
                   64'(rx_exp.pop_front()));
         end
      end
   end

   initial begin
      int n;
      bus.pe_tx_valid   = 1'b0;
      bus.pe_tx_dest    = '0;
      bus.pe_tx_type    = '0;
      bus.pe_tx_data    = '0;
      bus.net_out_ready = 1'b0;
      bus.net_in_valid  = 1'b0;
      bus.net_in_flit   = '0;
      bus.pe_rx_ready   = 1'b0;

      #12;
      chk("rst_tx_ready",  64'(bus.pe_tx_ready),   64'd0);
      chk("rst_out_valid", 64'(bus.net_out_valid), 64'd0);
      chk("rst_in_ready",  64'(bus.net_in_ready),  64'd0);
      chk("rst_rx_valid",  64'(bus.pe_rx_valid),   64'd0);
      chk("rst_level",     64'(tx_level),          64'd0);

      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("tx_ready_before_edge", 64'(bus.pe_tx_ready), 64'd0);
      @(negedge clk);
      chk("tx_ready_after_rst", 64'(bus.pe_tx_ready),  64'd1);
      chk("in_ready_after_rst", 64'(bus.net_in_ready), 64'd1);
      step();

      // single send, one-cycle latency
      tx_send(4'h9, 2'b00, 25'h0000ABC);
      @(negedge clk);
      chk("single_valid", 64'(bus.net_out_valid), 64'd1);
      chk("single_flit",  64'(bus.net_out_flit),  64'({4'h9, 4'h5, 2'b00, 25'h0000ABC}));
      step();
      bus.net_out_ready = 1'b1;
      tx_drain();

      // backpressure to full, then drain at one flit per cycle
      bus.net_out_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         tx_send(4'(i), 2'(i), 25'(32'h100 * i + 7));
         @(negedge clk);
         chk("bp_level", 64'(tx_level), 64'(i));
         step();
      end
      chk("bp_tx_ready_full", 64'(bus.pe_tx_ready), 64'd0);
      n = 0;
      fork
         tx_send(4'hF, 2'b11, 25'h1234567);
         begin
            step();
            step();
            bus.net_out_ready = 1'b1;
            repeat (5) begin
               @(negedge clk);
               if (bus.net_out_valid && bus.net_out_ready) n++;
            end
         end
      join
      chk("bp_throughput", 64'(n), 64'd5);
      tx_drain();

      // back-to-back mix, including dest equal to the local node
      tx_send(4'h5, 2'b01, 25'h0AAAAAA);
      for (int i = 0; i < 6; i++)
         tx_send(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 25'($urandom));
      tx_drain();

      // local receive
      rx_send({4'h5, 4'h2, 2'b10, 25'h1FFFFFF});
      @(negedge clk);
      chk("rx_local_valid", 64'(bus.pe_rx_valid), 64'd1);
      chk("rx_local_src",   64'(bus.pe_rx_src),   64'd2);
      chk("rx_local_type",  64'(bus.pe_rx_type),  64'd2);
      chk("rx_local_data",  64'(bus.pe_rx_data),  64'h1FFFFFF);
      step();
      bus.pe_rx_ready = 1'b1;
      rx_drain();

      // rx stall: skid buffer fills at two entries
      bus.pe_rx_ready = 1'b0;
      rx_send({4'h5, 4'h1, 2'b00, 25'h0000011});
      rx_send({4'h5, 4'h3, 2'b01, 25'h0000022});
      @(negedge clk);
      chk("rx_stall_in_ready", 64'(bus.net_in_ready), 64'd0);
      step();
      fork
         rx_send({4'h5, 4'hC, 2'b11, 25'h0000033});
         begin
            step();
            step();
            bus.pe_rx_ready = 1'b1;
         end
      join
      rx_drain();

      // TX and RX together
      fork
         for (int i = 0; i < 4; i++) tx_send(4'(i + 8), 2'(i), 25'(i * 3 + 1));
         for (int i = 0; i < 4; i++) rx_send({4'h5, 4'(i), 2'(3 - i), 25'(i * 5 + 2)});
      join
      tx_drain();
      rx_drain();

      // misroute saturation
      for (int i = 0; i < 300; i++) begin
         rx_send({4'h3, 4'(i % 16), 2'(i % 4), 25'(i)});
         if (i == 253) begin
            @(negedge clk);
            chk("misroute_254", 64'(misroute_cnt), 64'd254);
            step();
         end
      end
      @(negedge clk);
      chk("misroute_sat", 64'(misroute_cnt), 64'd255);
      step();

      // async reset with traffic queued
      bus.net_out_ready = 1'b0;
      bus.pe_rx_ready   = 1'b0;
      tx_send(4'h1, 2'b00, 25'h0000101);
      tx_send(4'h2, 2'b01, 25'h0000202);
      tx_send(4'h3, 2'b10, 25'h0000303);
      rx_send({4'h5, 4'h7, 2'b00, 25'h0000444});
      rx_send({4'h5, 4'h8, 2'b01, 25'h0000555});
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_tx_ready",  64'(bus.pe_tx_ready),   64'd0);
      chk("arst_out_valid", 64'(bus.net_out_valid), 64'd0);
      chk("arst_out_flit",  64'(bus.net_out_flit),  64'd0);
      chk("arst_in_ready",  64'(bus.net_in_ready),  64'd0);
      chk("arst_rx_valid",  64'(bus.pe_rx_valid),   64'd0);
      chk("arst_rx_data",   64'(bus.pe_rx_data),    64'd0);
      chk("arst_misroute",  64'(misroute_cnt),      64'd0);
      chk("arst_level",     64'(tx_level),          64'd0);
      tx_exp.delete();
      rx_exp.delete();
      bus.net_out_ready = 1'b1;
      bus.pe_rx_ready   = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_tx_ready", 64'(bus.pe_tx_ready),  64'd1);
      chk("post_rst_in_ready", 64'(bus.net_in_ready), 64'd1);
      repeat (5) @(negedge clk);
      chk("post_rst_no_stale_tx", 64'(bus.net_out_valid), 64'd0);
      chk("post_rst_no_stale_rx", 64'(bus.pe_rx_valid),   64'd0);
      chk("post_rst_level",       64'(tx_level),          64'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
